register_sync_chain: RTL and testbench

- Parameterized multi-bit synchronizer that carries a data vector from a foreign clock domain into the local `clk` domain through a chain of flip-flop stages.
- Used wherever asynchronous status (e.g. a VSYNC level sampled in the video clock domain) must be read by logic in the system clock domain.
- Provides a clock-enable-qualified shift chain and a per-bit change flag on the synchronized output.

---
 rtl/register_sync_chain.sv | 62 ++++++
 tb/tb_register_sync_chain.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/register_sync_chain.sv
// register_sync_chain
//   Multi-bit level synchronizer. It carries reg_i from a foreign clock domain
//   into the clk domain through a chain of sync_stages flip-flop stages. Every
//   bit is synchronized on its own, so cross-bit coherency is not guaranteed.
//   A multi-bit value that must stay coherent needs a single-bit-change
//   encoding, such as Gray code.
//
// Ports
//   clk     : sole clock, rising edge
//   nrst    : synchronous active-low reset; loads reg_preset and overrides clk_en
//   clk_en  : the chain and the history register advance only while high
//   reg_i   : asynchronous input vector (foreign domain)
//   reg_o   : synchronized vector, taken from the last chain stage
//   reg_chg : per-bit flag; reg_o differs from its value before the most
//             recent enabled update
module register_sync_chain #(
  parameter int                   reg_width   = 1,
  parameter logic [reg_width-1:0] reg_preset  = '0,
  parameter int                   sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clk_en,
  input  logic [reg_width-1:0] reg_i,
  output logic [reg_width-1:0] reg_o,
  output logic [reg_width-1:0] reg_chg
);

  // The stage count is clamped to 2..8.
  localparam int STAGES = (sync_stages < 2) ? 2 :
                          (sync_stages > 8) ? 8 : sync_stages;
  localparam int PIPE_W = STAGES * reg_width;

  // All stages are packed into one vector. Stage k occupies bits
  // [k*reg_width +: reg_width], so stage 0 (the metastability-capturing
  // flop) is the low slice. The attributes keep the tools from merging,
  // retiming or shift-register-extracting the chain. Only the last stage
  // leaves this module.
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [PIPE_W-1:0]    r_pipe = {STAGES{reg_preset}};
  logic [reg_width-1:0] r_hist = reg_preset;

  logic [reg_width-1:0] w_last;

  assign w_last = r_pipe[PIPE_W-1 -: reg_width];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_pipe <= {STAGES{reg_preset}};
      r_hist <= reg_preset;
    end else if (clk_en) begin
      // The shift moves every stage up one slot and drops the new sample
      // into stage 0.
      r_pipe <= {r_pipe[PIPE_W-reg_width-1:0], reg_i};
      r_hist <= w_last;
    end
  end

  assign reg_o   = w_last;
  assign reg_chg = w_last ^ r_hist;

endmodule

// File: tb/tb_register_sync_chain.sv
module tb_register_sync_chain;

  logic       clk    = 1'b0;
  logic       nrst   = 1'b0;
  logic       clk_en = 1'b0;
  logic [7:0] din    = 8'h00;

  logic [7:0] oa, ca;
  logic [3:0] ob, cb;
  logic [0:0] oc, cc;

  // Three instances: A has depth 3, B asks for 12 (clamped to 8),
  // C asks for 1 (clamped to 2).
  register_sync_chain #(.reg_width(8), .reg_preset(8'hA5), .sync_stages(3)) u_a (
    .clk(clk), .nrst(nrst), .clk_en(clk_en), .reg_i(din), .reg_o(oa), .reg_chg(ca));
  register_sync_chain #(.reg_width(4), .reg_preset(4'hA), .sync_stages(12)) u_b (
    .clk(clk), .nrst(nrst), .clk_en(clk_en), .reg_i(din[3:0]), .reg_o(ob), .reg_chg(cb));
  register_sync_chain #(.reg_width(1), .reg_preset(1'b0), .sync_stages(1)) u_c (
    .clk(clk), .nrst(nrst), .clk_en(clk_en), .reg_i(din[0:0]), .reg_o(oc), .reg_chg(cc));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] oa;
    logic [7:0] ca;
    logic [3:0] ob;
    logic [3:0] cb;
    logic       oc;
    logic       cc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] smp[$];   // values sampled on enabled edges since the last reset
  int         n_vec = 0;
  int         n_err = 0;

  // Reference model: reg_o is the sample taken n enabled edges ago, or the
  // preset if fewer than n samples have been taken since reset.
  function automatic logic [7:0] ago(int n, logic [7:0] pre);
    if (smp.size() >= n) return smp[smp.size() - n];
    return pre;
  endfunction

  function automatic exp_t model();
    exp_t       e;
    logic [7:0] t0, t1;
    e.oa = ago(3, 8'hA5);
    e.ca = e.oa ^ ago(4, 8'hA5);
    t0 = ago(8, 8'h0A);
    t1 = ago(9, 8'h0A);
    e.ob = t0[3:0];
    e.cb = t0[3:0] ^ t1[3:0];
    t0 = ago(2, 8'h00);
    t1 = ago(3, 8'h00);
    e.oc = t0[0];
    e.cc = t0[0] ^ t1[0];
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then push the expected outputs
  // for the following rising edge.
  task automatic drive(input logic r, input logic e, input logic [7:0] d);
    @(negedge clk);
    nrst   = r;
    clk_en = e;
    din    = d;
    if (!r) smp.delete();
    else if (e) begin
      smp.push_back(d);
      if (smp.size() > 12) void'(smp.pop_front());
    end
    exp_q.push_back(model());
  endtask

  // Monitor: sample 1 time unit after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("A.reg_o",   oa, e.oa);
        chk("A.reg_chg", ca, e.ca);
        chk("B.reg_o",   {4'h0, ob}, {4'h0, e.ob});
        chk("B.reg_chg", {4'h0, cb}, {4'h0, e.cb});
        chk("C.reg_o",   {7'h0, oc}, {7'h0, e.oc});
        chk("C.reg_chg", {7'h0, cc}, {7'h0, e.cc});
      end
    end
  end

  typedef struct packed {
    logic       r;
    logic       e;
    logic [7:0] d;
  } stim_t;

  stim_t dir[] = '{
    // reset held with enable high and input != preset
    '{1'b0, 1'b1, 8'h05}, '{1'b0, 1'b1, 8'h05}, '{1'b0, 1'b1, 8'h05},
    // latency: 0 -> 1 step
    '{1'b1, 1'b1, 8'h00}, '{1'b1, 1'b1, 8'h00}, '{1'b1, 1'b1, 8'h00},
    '{1'b1, 1'b1, 8'hFF}, '{1'b1, 1'b1, 8'hFF}, '{1'b1, 1'b1, 8'hFF}, '{1'b1, 1'b1, 8'hFF},
    // clock enable 1,0,0,1 with a held new value
    '{1'b1, 1'b1, 8'h00}, '{1'b1, 1'b1, 8'h00}, '{1'b1, 1'b1, 8'h00}, '{1'b1, 1'b1, 8'h00},
    '{1'b1, 1'b1, 8'hFF}, '{1'b1, 1'b0, 8'hFF}, '{1'b1, 1'b0, 8'hFF}, '{1'b1, 1'b1, 8'hFF},
    '{1'b1, 1'b0, 8'hFF}, '{1'b1, 1'b1, 8'hFF},
    // deep chain: 3C then C3 on consecutive cycles
    '{1'b1, 1'b1, 8'h3C}, '{1'b1, 1'b1, 8'hC3}, '{1'b1, 1'b1, 8'hC3},
    '{1'b1, 1'b1, 8'hC3}, '{1'b1, 1'b1, 8'hC3},
    // reset mid-flight
    '{1'b1, 1'b1, 8'h00}, '{1'b1, 1'b1, 8'h00}, '{1'b1, 1'b1, 8'h00}, '{1'b1, 1'b1, 8'h00},
    '{1'b1, 1'b1, 8'hFF}, '{1'b1, 1'b1, 8'hFF}, '{1'b0, 1'b1, 8'hFF},
    '{1'b1, 1'b1, 8'hFF}, '{1'b1, 1'b1, 8'hFF}, '{1'b1, 1'b1, 8'hFF}, '{1'b1, 1'b1, 8'hFF},
    // reset priority over enable, and reset with enable low
    '{1'b1, 1'b1, 8'h77}, '{1'b0, 1'b1, 8'h77}, '{1'b1, 1'b1, 8'h12}, '{1'b0, 1'b0, 8'h12},
    '{1'b1, 1'b0, 8'h34}, '{1'b1, 1'b0, 8'h34}
  };

  initial begin
    foreach (dir[i]) drive(dir[i].r, dir[i].e, dir[i].d);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) >= 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            8'($urandom));
    end
    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
